fetch_arbiter: RTL and testbench

FETCH_ARBITER -- requirements
Module: fetch_arbiter

---
 rtl/fetch_arbiter.sv | 106 ++++++++++
 tb/tb_fetch_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one byte-wide async-read memory between an instruction
// and a data requester; each grant reads four bytes and assembles a big-endian word.
module fetch_arbiter #(
  parameter int unsigned A_WIDTH = 20,
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req,
  input  logic [A_WIDTH-1:0] i_addr,
  output logic               i_valid,
  output logic [31:0]        i_rdata,
  input  logic               d_req,
  input  logic [A_WIDTH-1:0] d_addr,
  output logic               d_valid,
  output logic [31:0]        d_rdata,
  output logic [A_WIDTH-1:0] mem_addr,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e             state_q;
  logic [1:0]         cnt_q;
  logic [A_WIDTH-1:0] base_q;
  logic               owner_data_q;
  logic               last_data_q;
  logic [31:0]        asm_q;
  logic [31:0]        asm_d;
  logic [31:0]        i_rdata_q;
  logic [31:0]        d_rdata_q;
  logic               i_valid_q;
  logic               d_valid_q;
  logic               grant_data;
  logic [7:0]         beat;

  assign beat = mem_rdata[7:0];

  // Data wins when it is the only requester, or on a conflict if instruction went last.
  assign grant_data = d_req & (~i_req | ~last_data_q);

  always_comb begin
    asm_d = asm_q;
    unique case (cnt_q)
      2'd0: asm_d[31:24] = beat;
      2'd1: asm_d[23:16] = beat;
      2'd2: asm_d[15:8]  = beat;
      2'd3: asm_d[7:0]   = beat;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      base_q       <= '0;
      owner_data_q <= 1'b0;
      last_data_q  <= 1'b0;
      asm_q        <= 32'd0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            state_q      <= StRead;
            cnt_q        <= 2'd0;
            base_q       <= grant_data ? d_addr : i_addr;
            owner_data_q <= grant_data;
            last_data_q  <= grant_data;
          end
        end
        StRead: begin
          asm_q <= asm_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Last byte comes straight from asm_d so the word is complete on DONE entry.
            state_q <= StDone;
            if (owner_data_q) begin
              d_rdata_q <= asm_d;
              d_valid_q <= 1'b1;
            end else begin
              i_rdata_q <= asm_d;
              i_valid_q <= 1'b1;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_addr = (state_q == StRead) ? base_q + A_WIDTH'(cnt_q) : '0;
  assign busy     = (state_q != StIdle);
  assign i_valid  = i_valid_q;
  assign d_valid  = d_valid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration, reset mid-read and request drop.
module tb_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req;
  logic [19:0] i_addr, d_addr;
  logic        i_valid, d_valid;
  logic [31:0] i_rdata, d_rdata;
  logic [19:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  logic [31:0] exp_i_rd, exp_d_rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_arbiter #(.A_WIDTH(20), .D_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [7:0] mb(input logic [19:0] a);
    case (a)
      20'h0: mb = 8'h13;
      20'h1: mb = 8'h05;
      20'h2: mb = 8'h10;
      20'h3: mb = 8'h00;
      default: mb = a[7:0] ^ {a[15:12], a[19:16]} ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [19:0] a);
    logic [19:0] a1, a2, a3;
    a1 = a + 20'd1;
    a2 = a + 20'd2;
    a3 = a + 20'd3;
    word_at = {mb(a), mb(a1), mb(a2), mb(a3)};
  endfunction

  assign mem_rdata = mb(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("valid_overlap", {31'd0, i_valid & d_valid}, 32'd0);
  end

  // Runs one transaction from a negedge in IDLE through to the following IDLE.
  task automatic do_txn(input string name, input logic ir, input logic dr,
                        input logic [19:0] ia, input logic [19:0] da,
                        input logic exp_d, input logic hold);
    logic [19:0] base;
    logic [19:0] ea;
    base = exp_d ? da : ia;
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_idle_addr"}, {12'd0, mem_addr}, 32'd0);
    i_req = ir; d_req = dr; i_addr = ia; d_addr = da;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      ea = base + 20'(b);
      chk({name, "_rd_busy"}, {31'd0, busy}, 32'd1);
      chk({name, "_rd_addr"}, {12'd0, mem_addr}, {12'd0, ea});
      chk({name, "_rd_valid"}, {30'd0, i_valid, d_valid}, 32'd0);
      if (b < 3) @(negedge clk);
    end
    @(negedge clk);
    if (exp_d) exp_d_rd = word_at(base);
    else exp_i_rd = word_at(base);
    chk({name, "_done_valid"}, {30'd0, i_valid, d_valid}, exp_d ? 32'd1 : 32'd2);
    chk({name, "_i_rdata"}, i_rdata, exp_i_rd);
    chk({name, "_d_rdata"}, d_rdata, exp_d_rd);
    chk({name, "_done_addr"}, {12'd0, mem_addr}, 32'd0);
    if (last_valid_cyc >= 0 && hold) chk({name, "_spacing"}, 32'(cyc - last_valid_cyc), 32'd6);
    last_valid_cyc = cyc;
    if (!hold) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    @(negedge clk);
    chk({name, "_after_valid"}, {30'd0, i_valid, d_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    exp_i_rd = '0; exp_d_rd = '0;
    last_valid_cyc = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic        ir;
    logic        dr;
    logic [19:0] ia;
    logic [19:0] da;
    logic        exp_d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"i_only_0",    1'b1, 1'b0, 20'h00000, 20'h00000, 1'b0};
    vecs[1] = '{"both_d_first", 1'b1, 1'b1, 20'h00000, 20'h00004, 1'b1};
    vecs[2] = '{"both_i_next",  1'b1, 1'b1, 20'h00000, 20'h00004, 1'b0};
    vecs[3] = '{"d_wrap",       1'b0, 1'b1, 20'h00000, 20'hFFFFE, 1'b1};
    vecs[4] = '{"i_unaligned",  1'b1, 1'b0, 20'h00013, 20'h00000, 1'b0};
    vecs[5] = '{"both_d_again", 1'b1, 1'b1, 20'h00100, 20'h12345, 1'b1};

    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {30'd0, i_valid, d_valid}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_addr", {12'd0, mem_addr}, 32'd0);
    do_reset();

    for (int v = 0; v < 6; v++) begin
      do_txn(vecs[v].name, vecs[v].ir, vecs[v].dr, vecs[v].ia, vecs[v].da,
             vecs[v].exp_d, 1'b0);
      if (v == 0) chk("i_word_const", i_rdata, 32'h13051000);
    end

    // Continuous contention after reset: D, I, D, I.
    do_reset();
    for (int t = 0; t < 4; t++)
      do_txn("alt", 1'b1, 1'b1, 20'h00000, 20'h00004, (t % 2) == 0, 1'b1);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Reset pulsed during the third READ beat.
    do_reset();
    i_req = 1'b1; i_addr = 20'h00100;
    repeat (3) @(negedge clk);
    chk("mid_rst_beat2_addr", {12'd0, mem_addr}, 32'h00102);
    #1 rst_n = 1'b0;
    #1;
    i_req = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_addr", {12'd0, mem_addr}, 32'd0);
    chk("mid_rst_rdata", i_rdata | d_rdata, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mid_rst_valid", {30'd0, i_valid, d_valid}, 32'd0);
    end
    rst_n = 1'b1;
    exp_i_rd = '0; exp_d_rd = '0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_valid", {30'd0, i_valid, d_valid}, 32'd0);
    do_txn("post_rst_fresh", 1'b1, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0);

    // i_req dropped after first beat; d_req raised while busy waits for IDLE.
    i_req = 1'b1; i_addr = 20'h00040;
    @(negedge clk);
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b1; d_addr = 20'h00200;
    @(negedge clk);
    chk("drop_busy_addr", {12'd0, mem_addr}, 32'h00042);
    @(negedge clk);
    @(negedge clk);
    exp_i_rd = word_at(20'h00040);
    chk("drop_i_valid", {30'd0, i_valid, d_valid}, 32'd2);
    chk("drop_i_rdata", i_rdata, exp_i_rd);
    @(negedge clk);
    do_txn("late_d", 1'b0, 1'b1, 20'h00000, 20'h00200, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
